imuldiv_int_div_iterative_param: RTL and testbench

Parametrised iterative restoring divider that computes quotient and remainder one bit per cycle for WIDTH-bit operands. It supports signed and unsigned modes and has a defined divide-by-zero fast path. It sits behind the muldiv request/response val/rdy interfaces as the next-generation divide unit, and any WIDTH can be instantiated (32 for the PARC core, 8/16 for unit test).

---
 rtl/imuldiv_int_div_iterative_param_if.sv | 24 ++
 rtl/imuldiv_int_div_iterative_param.sv | 116 +++++++++++
 tb/tb_imuldiv_int_div_iterative_param.sv | 294 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/imuldiv_int_div_iterative_param_if.sv
// Request/response val/rdy bundle between a muldiv requester and the iterative divider.
// The master drives requests and accepts responses; the slave is the divider.
interface imuldiv_int_div_iterative_param_if #(
  parameter int unsigned WIDTH = 32
);
  logic               divreq_msg_fn;
  logic [WIDTH-1:0]   divreq_msg_a;
  logic [WIDTH-1:0]   divreq_msg_b;
  logic               divreq_val;
  logic               divreq_rdy;
  logic [2*WIDTH-1:0] divresp_msg_result;
  logic               divresp_val;
  logic               divresp_rdy;

  modport master (
    output divreq_msg_fn, divreq_msg_a, divreq_msg_b, divreq_val, divresp_rdy,
    input  divreq_rdy, divresp_msg_result, divresp_val
  );

  modport slave (
    input  divreq_msg_fn, divreq_msg_a, divreq_msg_b, divreq_val, divresp_rdy,
    output divreq_rdy, divresp_msg_result, divresp_val
  );
endinterface

// File: rtl/imuldiv_int_div_iterative_param.sv
// Iterative restoring divider: one quotient bit per cycle, signed/unsigned, with a
// single-cycle divide-by-zero path. Result is {remainder, quotient}.
module imuldiv_int_div_iterative_param #(
  parameter int unsigned WIDTH = 32
) (
  input logic                                clk,
  input logic                                reset,
  imuldiv_int_div_iterative_param_if.slave   div
);
  localparam int unsigned CNT_W = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {StIdle, StCalc, StDone} state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [2*WIDTH:0]   work_q, work_d;
  logic [WIDTH-1:0]   dvsr_q, dvsr_d;
  logic [WIDTH-1:0]   quot_q, quot_d;
  logic [WIDTH-1:0]   rem_q, rem_d;
  logic               sign_a_q, sign_a_d;
  logic               sign_b_q, sign_b_d;

  // Signs are only meaningful in signed mode, so they are masked by fn at capture.
  logic             a_neg, b_neg;
  logic [WIDTH-1:0] a_mag, b_mag;

  assign a_neg = !div.divreq_msg_fn && div.divreq_msg_a[WIDTH-1];
  assign b_neg = !div.divreq_msg_fn && div.divreq_msg_b[WIDTH-1];
  assign a_mag = a_neg ? -div.divreq_msg_a : div.divreq_msg_a;
  assign b_mag = b_neg ? -div.divreq_msg_b : div.divreq_msg_b;

  logic [2*WIDTH:0] shifted;
  logic [WIDTH:0]   diff;
  logic [2*WIDTH:0] step;
  logic [WIDTH-1:0] q_raw, r_raw, q_fix, r_fix;

  assign shifted = work_q << 1;
  assign diff    = shifted[2*WIDTH:WIDTH] - {1'b0, dvsr_q};
  // Restore by keeping the shifted value whenever the trial subtraction went negative.
  assign step    = diff[WIDTH] ? shifted : {diff, shifted[WIDTH-1:1], 1'b1};
  assign q_raw   = step[WIDTH-1:0];
  assign r_raw   = step[2*WIDTH-1:WIDTH];
  assign q_fix   = (sign_a_q ^ sign_b_q) ? -q_raw : q_raw;
  assign r_fix   = sign_a_q ? -r_raw : r_raw;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    work_d   = work_q;
    dvsr_d   = dvsr_q;
    quot_d   = quot_q;
    rem_d    = rem_q;
    sign_a_d = sign_a_q;
    sign_b_d = sign_b_q;
    unique case (state_q)
      StIdle: begin
        if (div.divreq_val) begin
          sign_a_d = a_neg;
          sign_b_d = b_neg;
          work_d   = {{(WIDTH + 1){1'b0}}, a_mag};
          dvsr_d   = b_mag;
          if (div.divreq_msg_b == '0) begin
            quot_d  = '1;
            rem_d   = div.divreq_msg_a;
            state_d = StDone;
          end else begin
            cnt_d   = CNT_W'(WIDTH);
            state_d = StCalc;
          end
        end
      end
      StCalc: begin
        work_d = step;
        cnt_d  = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          quot_d  = q_fix;
          rem_d   = r_fix;
          state_d = StDone;
        end
      end
      StDone: begin
        if (div.divresp_rdy) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      work_q   <= '0;
      dvsr_q   <= '0;
      quot_q   <= '0;
      rem_q    <= '0;
      sign_a_q <= 1'b0;
      sign_b_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      work_q   <= work_d;
      dvsr_q   <= dvsr_d;
      quot_q   <= quot_d;
      rem_q    <= rem_d;
      sign_a_q <= sign_a_d;
      sign_b_q <= sign_b_d;
    end
  end

  // Ready is gated by reset so nothing looks acceptable while reset is held.
  assign div.divreq_rdy         = (state_q == StIdle) && reset;
  assign div.divresp_val        = (state_q == StDone);
  assign div.divresp_msg_result = {rem_q, quot_q};
endmodule

// File: tb/tb_imuldiv_int_div_iterative_param.sv
// Bench for the iterative divider: 32-bit instance checked every cycle against a queue of
// arithmetic-model results, plus a small 8-bit instance for parametrisation.
module tb_imuldiv_int_div_iterative_param;
  localparam int unsigned W  = 32;
  localparam int unsigned W8 = 8;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  int   n_checks = 0;
  int   n_pass   = 0;

  typedef struct {
    logic [63:0] res;
    int          lat;
  } exp_t;

  exp_t        exp_q[$];
  int          acc_cnt  = 0;
  logic [63:0] last_res = '0;

  bit          d_fn[7]  = '{1, 0, 0, 0, 1, 0, 1};
  logic [31:0] d_a[7]   = '{32'd100, 32'hFFFF_FFF9, 32'd7, 32'h1234, 32'h1234,
                            32'h8000_0000, 32'h8000_0000};
  logic [31:0] d_b[7]   = '{32'd7, 32'd2, 32'hFFFF_FFFE, 32'd0, 32'd0,
                            32'hFFFF_FFFF, 32'hFFFF_FFFF};
  logic [63:0] d_exp[7] = '{{32'd2, 32'd14}, {32'hFFFF_FFFF, 32'hFFFF_FFFD},
                            {32'd1, 32'hFFFF_FFFD}, {32'h1234, 32'hFFFF_FFFF},
                            {32'h1234, 32'hFFFF_FFFF}, {32'd0, 32'h8000_0000},
                            {32'h8000_0000, 32'd0}};
  int          d_lat[7] = '{33, 33, 33, 1, 1, 33, 33};

  always #5 clk = ~clk;

  imuldiv_int_div_iterative_param_if #(.WIDTH(W))  bus  ();
  imuldiv_int_div_iterative_param_if #(.WIDTH(W8)) bus8 ();

  imuldiv_int_div_iterative_param #(.WIDTH(W)) dut (
    .clk   (clk),
    .reset (rst_n),
    .div   (bus)
  );

  imuldiv_int_div_iterative_param #(.WIDTH(W8)) dut8 (
    .clk   (clk),
    .reset (rst_n),
    .div   (bus8)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
  endtask

  // Plain arithmetic reference: truncating division, remainder takes the dividend's sign.
  function automatic void model(input int w, input bit fn, input logic [63:0] a_in,
                                input logic [63:0] b_in, output logic [63:0] q,
                                output logic [63:0] r);
    logic [63:0] mask, a, b;
    longint      sa, sb;
    mask = (w >= 64) ? '1 : ((64'd1 << w) - 64'd1);
    a = a_in & mask;
    b = b_in & mask;
    if (b == 0) begin
      q = mask;
      r = a;
    end else if (fn) begin
      q = a / b;
      r = a % b;
    end else begin
      sa = $signed(a << (64 - w));
      sa = sa >>> (64 - w);
      sb = $signed(b << (64 - w));
      sb = sb >>> (64 - w);
      q  = sa / sb;
      r  = sa % sb;
    end
    q = q & mask;
    r = r & mask;
  endfunction

  always @(negedge clk) begin : mon
    logic [63:0] q, r;
    if (!rst_n) begin
      check("rst_req_rdy", bus.divreq_rdy, 0);
      check("rst_resp_val", bus.divresp_val, 0);
      check("rst_result", bus.divresp_msg_result, 0);
      exp_q.delete();
      acc_cnt = 0;
    end else begin
      if (exp_q.size() != 0) acc_cnt++;
      check("req_rdy", bus.divreq_rdy, exp_q.size() == 0);
      if (exp_q.size() != 0) begin
        check("resp_val", bus.divresp_val, acc_cnt >= exp_q[0].lat);
        if (bus.divresp_val) begin
          check("resp_result", bus.divresp_msg_result, exp_q[0].res);
          if (bus.divresp_rdy) begin
            last_res = bus.divresp_msg_result;
            void'(exp_q.pop_front());
          end
        end
      end else begin
        check("resp_val_idle", bus.divresp_val, 0);
      end
      if (bus.divreq_val && bus.divreq_rdy) begin
        model(W, bus.divreq_msg_fn, bus.divreq_msg_a, bus.divreq_msg_b, q, r);
        exp_q.push_back('{res: {r[31:0], q[31:0]},
                          lat: (bus.divreq_msg_b == 0) ? 1 : int'(W + 1)});
        acc_cnt = 0;
      end
    end
  end

  task automatic issue(input bit fn, input logic [31:0] a, input logic [31:0] b);
    bit ok = 1'b0;
    @(posedge clk); #1;
    bus.divreq_msg_fn = fn;
    bus.divreq_msg_a  = a;
    bus.divreq_msg_b  = b;
    bus.divreq_val    = 1'b1;
    for (int i = 0; i < 100 && !ok; i++) begin
      @(negedge clk);
      ok = bus.divreq_rdy;
    end
    if (!ok) check("accept_timeout", bus.divreq_rdy, 1);
    @(posedge clk); #1;
    // Scramble operands after the accept edge; they must not influence the result.
    bus.divreq_val    = 1'b0;
    bus.divreq_msg_a  = $urandom;
    bus.divreq_msg_b  = $urandom;
    bus.divreq_msg_fn = 1'($urandom);
  endtask

  task automatic complete(input int hold, output int lat);
    bit ok = 1'b0;
    lat = 0;
    for (int i = 0; i < int'(W) + 10 && !ok; i++) begin
      @(negedge clk);
      lat++;
      ok = bus.divresp_val;
    end
    if (!ok) check("resp_timeout", bus.divresp_val, 1);
    repeat (hold) @(negedge clk);
    @(posedge clk); #1 bus.divresp_rdy = 1'b1;
    @(posedge clk); #1 bus.divresp_rdy = 1'b0;
  endtask

  task automatic do_op(input bit fn, input logic [31:0] a, input logic [31:0] b,
                       input int hold, output int lat);
    issue(fn, a, b);
    complete(hold, lat);
  endtask

  task automatic do_op8(input bit fn, input logic [7:0] a, input logic [7:0] b,
                        output logic [15:0] res, output int lat);
    bit ok = 1'b0;
    @(posedge clk); #1;
    bus8.divreq_msg_fn = fn;
    bus8.divreq_msg_a  = a;
    bus8.divreq_msg_b  = b;
    bus8.divreq_val    = 1'b1;
    for (int i = 0; i < 100 && !ok; i++) begin
      @(negedge clk);
      ok = bus8.divreq_rdy;
    end
    if (!ok) check("w8_accept_timeout", bus8.divreq_rdy, 1);
    @(posedge clk); #1;
    bus8.divreq_val   = 1'b0;
    bus8.divreq_msg_a = 8'($urandom);
    ok  = 1'b0;
    lat = 0;
    for (int i = 0; i < 30 && !ok; i++) begin
      @(negedge clk);
      lat++;
      ok = bus8.divresp_val;
    end
    if (!ok) check("w8_resp_timeout", bus8.divresp_val, 1);
    res = bus8.divresp_msg_result;
    @(posedge clk); #1 bus8.divresp_rdy = 1'b1;
    @(posedge clk); #1 bus8.divresp_rdy = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int          lat, sel;
    bit          fn;
    logic [31:0] a, b;
    logic [63:0] q, r;
    logic [15:0] res8;

    bus.divreq_val  = 1'b0;  bus.divreq_msg_fn  = 1'b0;
    bus.divreq_msg_a = '0;   bus.divreq_msg_b   = '0;  bus.divresp_rdy  = 1'b0;
    bus8.divreq_val = 1'b0;  bus8.divreq_msg_fn = 1'b0;
    bus8.divreq_msg_a = '0;  bus8.divreq_msg_b  = '0;  bus8.divresp_rdy = 1'b0;

    #2 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    check("rdy_after_rst", bus.divreq_rdy, 1);
    check("rdy8_after_rst", bus8.divreq_rdy, 1);

    // Directed cases: pin the model with literals, then run the DUT against the same literals.
    for (int i = 0; i < 7; i++) begin
      model(W, d_fn[i], d_a[i], d_b[i], q, r);
      check("model_pin", {r[31:0], q[31:0]}, d_exp[i]);
      do_op(d_fn[i], d_a[i], d_b[i], i % 2, lat);
      check("dir_result", last_res, d_exp[i]);
      check("dir_latency", lat, d_lat[i]);
    end

    // Backpressure: result must hold and a waiting request must stay unaccepted.
    issue(1'b1, 32'd1000, 32'd3);
    complete_wait: for (int i = 0; i < int'(W) + 10; i++) begin
      @(negedge clk);
      if (bus.divresp_val) break;
    end
    @(posedge clk); #1;
    bus.divreq_msg_fn = 1'b1;
    bus.divreq_msg_a  = 32'd77;
    bus.divreq_msg_b  = 32'd7;
    bus.divreq_val    = 1'b1;
    repeat (5) begin
      @(negedge clk);
      check("bp_result", bus.divresp_msg_result, {32'd1, 32'd333});
      check("bp_req_rdy", bus.divreq_rdy, 0);
    end
    @(posedge clk); #1 bus.divresp_rdy = 1'b1;
    @(posedge clk); #1 bus.divresp_rdy = 1'b0;
    @(negedge clk);
    check("bp_idle_rdy", bus.divreq_rdy, 1);
    check("bp_val_low", bus.divresp_val, 0);
    @(posedge clk); #1 bus.divreq_val = 1'b0;
    complete(0, lat);
    check("bp_next_result", last_res, {32'd0, 32'd11});
    check("bp_next_latency", lat, 33);

    // Randomised operations with random response backpressure.
    for (int i = 0; i < 40; i++) begin
      fn  = 1'($urandom);
      a   = $urandom;
      sel = $urandom_range(0, 7);
      if (sel == 0) b = 32'd0;
      else if (sel <= 2) b = $urandom_range(1, 20);
      else if (sel == 3) begin
        b = 32'hFFFF_FFFF;
        if ($urandom_range(0, 1) == 1) a = 32'h8000_0000;
      end else b = $urandom;
      if (sel == 4) a = $urandom_range(0, 50);
      do_op(fn, a, b, $urandom_range(0, 3), lat);
    end

    // Reset mid-calculation aborts the op with no response afterwards.
    issue(1'b1, $urandom, 32'd5);
    repeat (10) @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("abort_req_rdy", bus.divreq_rdy, 0);
    check("abort_resp_val", bus.divresp_val, 0);
    repeat (3) @(negedge clk);
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    check("release_req_rdy", bus.divreq_rdy, 1);
    repeat (W + 5) @(negedge clk);
    check("no_stray_resp", bus.divresp_val, 0);
    do_op(1'b1, 32'd1000, 32'd10, 0, lat);
    check("post_reset_op", last_res, {32'd0, 32'd100});

    // 8-bit instance.
    model(W8, 1'b1, 64'd200, 64'd13, q, r);
    check("model8_pin", {r[7:0], q[7:0]}, {8'd5, 8'd15});
    do_op8(1'b1, 8'd200, 8'd13, res8, lat);
    check("w8_result", res8, {8'd5, 8'd15});
    check("w8_latency", lat, 9);
    for (int i = 0; i < 20; i++) begin
      fn  = 1'($urandom);
      a   = $urandom_range(0, 255);
      sel = $urandom_range(0, 5);
      b   = (sel == 0) ? 32'd0 : (sel == 1) ? 32'hFF : $urandom_range(1, 255);
      do_op8(fn, a[7:0], b[7:0], res8, lat);
      model(W8, fn, a, b, q, r);
      check("w8_rand_result", res8, {r[7:0], q[7:0]});
      check("w8_rand_latency", lat, (b == 0) ? 1 : 9);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
